hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage; the decoder routes mult/multu/div/divu to it instead of the ALU.
- Iterative radix-2 shift-add multiply and restoring divide, using the same 5-bit opcode encodings as the ALU.
- Start/busy/done handshake; results are held in HI/LO until overwritten.

---
 rtl/alu_defs_pkg.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 16 +
 rtl/hilo_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Definitions shared between the execute-stage ALU and the HI/LO mul/div unit.
// Optional macro: HILO_MULDIV_SQRT_EN makes OP_SQRT a supported opcode.
package alu_defs_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_MULT  = 5'd4;
  localparam logic [4:0] OP_DIV   = 5'd5;
  localparam logic [4:0] OP_MULTU = 5'd9;
  localparam logic [4:0] OP_DIVU  = 5'd10;
  localparam logic [4:0] OP_SQRT  = 5'd12;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_e;

  typedef enum logic [1:0] {K_MUL, K_DIV, K_SQRT} md_kind_e;

  function automatic logic op_supported(input logic [4:0] op);
    logic ok;
    ok = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MULTU) || (op == OP_DIVU);
`ifdef HILO_MULDIV_SQRT_EN
    ok = ok || (op == OP_SQRT);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both for operand magnitude
// capture and for result sign correction.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    o_val = i_neg ? (~i_val + W'(1)) : i_val;
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign
// correction in a final FIX cycle.
// Optional macro: HILO_MULDIV_SQRT_EN adds an unsigned integer square root.
module hilo_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      hilo_we,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            zero,
  output logic            neg,
  output logic            div_by_zero
);
  import alu_defs_pkg::*;

  localparam logic [CNT_W-1:0] LAST_MD = CNT_W'(XLEN - 1);
`ifdef HILO_MULDIV_SQRT_EN
  localparam logic [CNT_W-1:0] LAST_SQ = CNT_W'(XLEN / 2 - 1);
`endif

  md_state_e        r_state, w_state_nxt;
  md_kind_e         r_kind;
  logic [CNT_W-1:0] r_cnt, r_last;
  logic             r_signed, r_sa, r_sb;
  logic [XLEN-1:0]  r_hw, r_lw, r_opb;
  logic [XLEN-1:0]  r_hi, r_lo;
  logic             r_zero, r_neg, r_dbz;

  logic             w_accept, w_op_signed, w_op_mul, w_op_div, w_start_ok, w_dbz;
  logic [XLEN-1:0]  w_abs_a, w_abs_b;
  logic [XLEN-1:0]  w_hw_nxt, w_lw_nxt, w_opb_nxt;
  logic [XLEN:0]    w_msum, w_dshift;
  logic [XLEN-1:0]  w_dsub;
  logic             w_dgeq;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]  w_quo_fix, w_rem_fix;
`ifdef HILO_MULDIV_SQRT_EN
  logic [XLEN-1:0]  w_sshift, w_strial;
  logic             w_sgeq;
`endif

  assign w_accept    = (r_state == IDLE) || (r_state == DONE);
  assign w_op_signed = (opcode == OP_MULT) || (opcode == OP_DIV);
  assign w_op_mul    = (opcode == OP_MULT) || (opcode == OP_MULTU);
  assign w_op_div    = (opcode == OP_DIV)  || (opcode == OP_DIVU);
  assign w_start_ok  = start && w_accept && op_supported(opcode);
  assign w_dbz       = w_start_ok && w_op_div && (b == '0);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (
    .i_val(a), .i_neg(w_op_signed & a[XLEN-1]), .o_val(w_abs_a)
  );
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (
    .i_val(b), .i_neg(w_op_signed & b[XLEN-1]), .o_val(w_abs_b)
  );

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .i_val({r_hw, r_lw}), .i_neg(r_signed & (r_sa ^ r_sb)), .o_val(w_prod_fix)
  );
  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
    .i_val(r_lw), .i_neg(r_signed & (r_sa ^ r_sb)), .o_val(w_quo_fix)
  );
  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
    .i_val(r_hw), .i_neg(r_signed & r_sa), .o_val(w_rem_fix)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode plus busy/done outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = w_dbz ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == r_last) w_state_nxt = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (w_start_ok) w_state_nxt = w_dbz ? DONE : RUN;
        else            w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One iteration of the selected algorithm. The work registers are reused:
  // multiply keeps {partial-high, multiplier/product-low}, divide keeps
  // {remainder, dividend/quotient}, sqrt keeps {remainder, radicand} with the
  // root growing in r_opb.
  always_comb begin
    w_hw_nxt  = r_hw;
    w_lw_nxt  = r_lw;
    w_opb_nxt = r_opb;
    w_msum    = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_opb} : '0);
    w_dshift  = {r_hw, r_lw[XLEN-1]};
    w_dgeq    = (w_dshift >= {1'b0, r_opb});
    w_dsub    = w_dshift[XLEN-1:0] - r_opb;
`ifdef HILO_MULDIV_SQRT_EN
    w_sshift  = {r_hw[XLEN-3:0], r_lw[XLEN-1:XLEN-2]};
    w_strial  = {r_opb[XLEN-3:0], 2'b01};
    w_sgeq    = (w_sshift >= w_strial);
`endif
    case (r_kind)
      K_MUL: begin
        w_hw_nxt = w_msum[XLEN:1];
        w_lw_nxt = {w_msum[0], r_lw[XLEN-1:1]};
      end
      K_DIV: begin
        w_hw_nxt = w_dgeq ? w_dsub : w_dshift[XLEN-1:0];
        w_lw_nxt = {r_lw[XLEN-2:0], w_dgeq};
      end
`ifdef HILO_MULDIV_SQRT_EN
      K_SQRT: begin
        w_hw_nxt  = w_sgeq ? (w_sshift - w_strial) : w_sshift;
        w_lw_nxt  = {r_lw[XLEN-3:0], 2'b00};
        w_opb_nxt = {r_opb[XLEN-2:0], w_sgeq};
      end
`endif
      default: ;
    endcase
  end

  // Operand capture, iteration, result/flag writeback and mthi/mtlo writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind   <= K_MUL;
      r_cnt    <= '0;
      r_last   <= '0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_hw     <= '0;
      r_lw     <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (hilo_we[1]) r_hi <= hilo_wdata;
          if (hilo_we[0]) r_lo <= hilo_wdata;
          if (w_dbz) begin
            r_dbz  <= 1'b1;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
          end else if (w_start_ok) begin
            r_cnt    <= '0;
            r_signed <= w_op_signed;
            r_sa     <= a[XLEN-1];
            r_sb     <= b[XLEN-1];
            r_hw     <= '0;
            r_last   <= LAST_MD;
            if (w_op_mul) begin
              r_kind <= K_MUL;
              r_lw   <= w_abs_b;
              r_opb  <= w_abs_a;
            end else if (w_op_div) begin
              r_kind <= K_DIV;
              r_lw   <= w_abs_a;
              r_opb  <= w_abs_b;
            end
`ifdef HILO_MULDIV_SQRT_EN
            else begin
              r_kind <= K_SQRT;
              r_lw   <= a;
              r_opb  <= '0;
              r_last <= LAST_SQ;
            end
`endif
          end
        end
        RUN: begin
          r_hw  <= w_hw_nxt;
          r_lw  <= w_lw_nxt;
          r_opb <= w_opb_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_dbz <= 1'b0;
          case (r_kind)
            K_MUL: begin
              {r_hi, r_lo} <= w_prod_fix;
              r_zero       <= (w_prod_fix == '0);
              r_neg        <= r_signed & w_prod_fix[2*XLEN-1];
            end
            K_DIV: begin
              r_lo   <= w_quo_fix;
              r_hi   <= w_rem_fix;
              r_zero <= (w_quo_fix == '0);
              r_neg  <= r_signed & w_quo_fix[XLEN-1];
            end
`ifdef HILO_MULDIV_SQRT_EN
            K_SQRT: begin
              r_lo   <= r_opb;
              r_hi   <= r_hw;
              r_zero <= (r_opb == '0);
              r_neg  <= 1'b0;
            end
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign HI          = r_hi;
  assign LO          = r_lo;
  assign zero        = r_zero;
  assign neg         = r_neg;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus random traffic, checked each
// cycle against an arithmetic model of HI/LO, flags and handshake timing.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [4:0]  opcode;
  logic [31:0] a, b, hilo_wdata;
  logic [1:0]  hilo_we;
  logic        busy, done, zero, neg, div_by_zero;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  hilo_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .busy(busy), .done(done),
    .HI(HI), .LO(LO), .zero(zero), .neg(neg), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit tb_supported(input logic [4:0] op);
    bit ok;
    ok = (op == 5'd4) || (op == 5'd5) || (op == 5'd9) || (op == 5'd10);
`ifdef HILO_MULDIV_SQRT_EN
    ok = ok || (op == 5'd12);
`endif
    return ok;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_zero = 1'b0, m_neg = 1'b0, m_dbz = 1'b0, m_done = 1'b0;
  logic        p_zero = 1'b0, p_neg = 1'b0;
  int          m_left = 0;

  task automatic model_compute(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] pv;
    longint lo_r, hi_r, mid, xv;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (op)
      5'd4: begin
        pv = sx * sy;
        p_hi = pv[63:32]; p_lo = pv[31:0]; p_zero = (pv == 0); p_neg = pv[63];
      end
      5'd9: begin
        pv = {32'b0, x} * {32'b0, y};
        p_hi = pv[63:32]; p_lo = pv[31:0]; p_zero = (pv == 0); p_neg = 1'b0;
      end
      5'd5: begin
        sq = sx / sy; sr = sx % sy;
        p_lo = sq[31:0]; p_hi = sr[31:0]; p_zero = (p_lo == 0); p_neg = p_lo[31];
      end
      5'd10: begin
        p_lo = x / y; p_hi = x % y; p_zero = (p_lo == 0); p_neg = 1'b0;
      end
      default: begin
        xv = longint'({32'b0, x});
        lo_r = 0; hi_r = 65536;
        while (hi_r - lo_r > 1) begin
          mid = (lo_r + hi_r) / 2;
          if (mid * mid <= xv) lo_r = mid; else hi_r = mid;
        end
        p_lo = 32'(lo_r); p_hi = 32'(xv - lo_r * lo_r);
        p_zero = (lo_r == 0); p_neg = 1'b0;
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_zero = 0; m_neg = 0; m_dbz = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_zero = p_zero; m_neg = p_neg; m_dbz = 0; m_done = 1;
        end
      end else begin
        if (hilo_we[1]) m_hi = hilo_wdata;
        if (hilo_we[0]) m_lo = hilo_wdata;
        if (start && tb_supported(opcode)) begin
          if ((opcode == 5'd5 || opcode == 5'd10) && b == 0) begin
            m_dbz = 1; m_zero = 0; m_neg = 0; m_done = 1;
          end else begin
            model_compute(opcode, a, b);
            m_left = (opcode == 5'd12) ? 17 : 33;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_left > 0));
      chk("done", done, m_done);
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
      chk("zero", zero, m_zero);
      chk("neg", neg, m_neg);
      chk("div_by_zero", div_by_zero, m_dbz);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit now, output int lat);
    if (!now) begin
      @(posedge clk); #1;
    end
    start = 1'b1; opcode = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic expect_idle(input string name, input logic [4:0] op);
    int seen;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; opcode = op; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) seen++;
    end
    chk(name, seen, 0);
  endtask

  logic [4:0]  ops [8] = '{5'd4, 5'd5, 5'd9, 5'd10, 5'd12, 5'd0, 5'd3, 5'd31};
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

  function automatic logic [31:0] rand_opnd();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  initial begin
    int lat, dn;
    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0; hilo_we = '0; hilo_wdata = '0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_HI", HI, 0);
    chk("rst_LO", LO, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(5'd4, 32'hFFFFFFFE, 32'd3, 0, lat);
    chk("mult_lat", lat, 33);
    chk("mult_HI", HI, 32'hFFFFFFFF);
    chk("mult_LO", LO, 32'hFFFFFFFA);
    chk("mult_neg", neg, 1);
    chk("mult_zero", zero, 0);
    chk("model_mult_LO", m_lo, 32'hFFFFFFFA);

    do_op(5'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
    chk("multu_lat", lat, 33);
    chk("multu_HI", HI, 32'hFFFFFFFE);
    chk("multu_LO", LO, 32'h00000001);
    chk("multu_neg", neg, 0);
    chk("model_multu_HI", m_hi, 32'hFFFFFFFE);

    do_op(5'd5, 32'hFFFFFFF9, 32'd2, 0, lat);
    chk("div_LO", LO, 32'hFFFFFFFD);
    chk("div_HI", HI, 32'hFFFFFFFF);
    chk("model_div_HI", m_hi, 32'hFFFFFFFF);

    do_op(5'd5, 32'h80000000, 32'hFFFFFFFF, 0, lat);
    chk("divovf_LO", LO, 32'h80000000);
    chk("divovf_HI", HI, 32'h0);
    chk("model_divovf_LO", m_lo, 32'h80000000);

    do_op(5'd10, 32'd100, 32'd0, 0, lat);
    chk("dbz_lat", lat, 0);
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_LO_kept", LO, 32'h80000000);
    chk("dbz_HI_kept", HI, 32'h0);

    // New start issued while the dbz done pulse is high (accepted in DONE).
    do_op(5'd10, 32'd100, 32'd7, 1, lat);
    chk("divu_lat", lat, 33);
    chk("divu_LO", LO, 32'd14);
    chk("divu_HI", HI, 32'd2);
    chk("divu_dbz", div_by_zero, 0);

    @(posedge clk); #1;
    hilo_we = 2'b11; hilo_wdata = 32'h1234;
    @(posedge clk); #1;
    hilo_we = 2'b00;
    @(negedge clk);
    chk("mthilo_HI", HI, 32'h1234);
    chk("mthilo_LO", LO, 32'h1234);

    // Writes and starts while busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; opcode = 5'd9; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1; hilo_we = 2'b11; hilo_wdata = 32'hDEAD; start = 1'b1; opcode = 5'd10; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    hilo_we = 2'b00; start = 1'b0;
    lat = -1;
    for (int k = 6; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("busyign_lat", lat, 33);
    chk("busyign_LO", LO, 32'd15);
    chk("busyign_HI", HI, 32'd0);
    chk("busyign_dbz", div_by_zero, 0);

    expect_idle("unsup_op3", 5'd3);
`ifdef HILO_MULDIV_SQRT_EN
    do_op(5'd12, 32'd1000, 32'hFFFFFFFF, 0, lat);
    chk("sqrt_lat", lat, 17);
    chk("sqrt_LO", LO, 32'd31);
    chk("sqrt_HI", HI, 32'd39);
    chk("model_sqrt_LO", m_lo, 32'd31);
`else
    expect_idle("unsup_sqrt", 5'd12);
`endif

    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      start      = ($urandom_range(0, 5) == 0);
      opcode     = ops[$urandom_range(0, 7)];
      a          = rand_opnd();
      b          = ($urandom_range(0, 9) == 0) ? 32'h0 : rand_opnd();
      hilo_we    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hilo_wdata = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 2'b00;
    repeat (40) @(posedge clk);

    // Reset in the middle of an operation aborts it.
    do_op(5'd9, 32'd7, 32'd9, 0, lat);
    @(posedge clk); #1;
    start = 1'b1; opcode = 5'd4; a = 32'h12345; b = 32'h777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_HI", HI, 0);
    chk("abort_LO", LO, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
